// File: rtl/stream_remove_pkg.sv
// Shared types and helpers for the stream_remove command scheduler.
// The command record width follows the package-level requester count and
// byte-count width; the scheduler top derives its own widths from these.
package stream_remove_pkg;

  localparam int SR_DATA_WD      = 32;
  localparam int SR_DATA_BYTE_WD = SR_DATA_WD / 8;
  localparam int SR_BYTE_CNT_WD  = $clog2(SR_DATA_BYTE_WD);
  localparam int SR_NUM_REQ      = 4;
  localparam int SR_REQ_ID_WD    = $clog2(SR_NUM_REQ);
  localparam int SR_CMD_DEPTH    = 4;

  // One queued command: which requester owns the packet and how many bytes to strip.
  typedef struct packed {
    logic [SR_REQ_ID_WD-1:0]   src;
    logic [SR_BYTE_CNT_WD-1:0] cnt;
  } rm_cmd_t;

  // Convert a one-hot grant vector into the index of its set bit (0 when none).
  function automatic logic [SR_REQ_ID_WD-1:0] onehot_to_idx(input logic [SR_NUM_REQ-1:0] oh);
    logic [SR_REQ_ID_WD-1:0] idx;
    idx = '0;
    for (int i = 0; i < SR_NUM_REQ; i++) begin
      idx = idx | (oh[i] ? SR_REQ_ID_WD'(i) : SR_REQ_ID_WD'(0));
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_remove_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer with wrap and grants
// the first active requester. No grant is issued when advance is low.
module stream_remove_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int ID_WD  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [ID_WD-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // First-match search starting at the priority pointer.
  always_comb begin
    logic found_s;
    int   idx_s;
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    if (advance) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_s = (int'(ptr) + k) % NUM_REQ;
        if (!found_s && req[idx_s]) begin
          grant[idx_s] = 1'b1;
          found_s      = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/stream_remove_sched.sv
// Command scheduler in front of stream_remove: round-robin grant across
// requesters, a command FIFO, registered head outputs and per-source done pulses.
// Optional statistics (packet/byte counters with clear) are built only when
// STREAM_REMOVE_SCHED_STATS_EN is defined.
module stream_remove_sched
  import stream_remove_pkg::*;
#(
  parameter int DATA_WD      = SR_DATA_WD,
  parameter int NUM_REQ      = SR_NUM_REQ,
  parameter int CMD_DEPTH    = SR_CMD_DEPTH,
  localparam int DATA_BYTE_WD = DATA_WD / 8,
  localparam int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  localparam int REQ_ID_WD    = $clog2(NUM_REQ),
  localparam int PTR_WD       = $clog2(CMD_DEPTH),
  localparam int LVL_WD       = $clog2(CMD_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sched_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0] req_cnt,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           valid_remove,
  output logic [BYTE_CNT_WD-1:0]         byte_remove_cnt,
  input  logic                           ready_remove,
  output logic [REQ_ID_WD-1:0]           cur_src,
  output logic [NUM_REQ-1:0]             pkt_done,
`ifdef STREAM_REMOVE_SCHED_STATS_EN
  input  logic                           stat_clr,
  output logic [31:0]                    stat_pkts,
  output logic [31:0]                    stat_bytes,
`endif
  output logic [LVL_WD-1:0]              cmd_level
);

  rm_cmd_t              mem_r [CMD_DEPTH];
  rm_cmd_t              head_r;
  rm_cmd_t              head_nxt_s;
  rm_cmd_t              push_cmd_s;
  logic                 head_vld_r;
  logic [PTR_WD-1:0]    wr_ptr_r;
  logic [PTR_WD-1:0]    rd_ptr_r;
  logic [LVL_WD-1:0]    level_r;
  logic [LVL_WD-1:0]    level_nxt_s;
  logic [REQ_ID_WD-1:0] rr_ptr_r;
  logic [NUM_REQ-1:0]   grant_s;
  logic [NUM_REQ-1:0]   done_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 can_push_s;

  assign pop_s      = head_vld_r && ready_remove;
  assign can_push_s = sched_en && ((level_r < LVL_WD'(CMD_DEPTH)) || pop_s);
  assign push_s     = |grant_s;

  stream_remove_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .advance (can_push_s),
    .ptr     (rr_ptr_r),
    .grant   (grant_s)
  );

  // Build the command record for the granted requester.
  always_comb begin
    push_cmd_s     = '0;
    push_cmd_s.src = onehot_to_idx(grant_s);
    push_cmd_s.cnt = req_cnt[push_cmd_s.src*BYTE_CNT_WD +: BYTE_CNT_WD];
  end

  // Next occupancy and next head: the head moves only on pop or on push into an empty queue.
  always_comb begin
    level_nxt_s = level_r;
    head_nxt_s  = head_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_WD'(1);
      2'b01:   level_nxt_s = level_r - LVL_WD'(1);
      default: level_nxt_s = level_r;
    endcase
    if (level_nxt_s == LVL_WD'(0)) begin
      head_nxt_s = '0;
    end else if (push_s && ((level_r == LVL_WD'(0)) || (pop_s && (level_r == LVL_WD'(1))))) begin
      head_nxt_s = push_cmd_s;
    end else if (pop_s) begin
      head_nxt_s = mem_r[rd_ptr_r + PTR_WD'(1)];
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Command storage, written at wr_ptr on every accepted grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_cmd_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy, round-robin priority, head registers and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      rr_ptr_r   <= '0;
      head_r     <= '0;
      head_vld_r <= 1'b0;
      done_r     <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_WD'(1);
        rr_ptr_r <= (push_cmd_s.src == REQ_ID_WD'(NUM_REQ - 1)) ? REQ_ID_WD'(0)
                                                                 : push_cmd_s.src + REQ_ID_WD'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rr_ptr_r <= rr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_WD'(1);
        done_r   <= NUM_REQ'(1) << head_r.src;
      end else begin
        rd_ptr_r <= rd_ptr_r;
        done_r   <= '0;
      end
      level_r    <= level_nxt_s;
      head_r     <= head_nxt_s;
      head_vld_r <= (level_nxt_s != LVL_WD'(0));
    end
  end

`ifdef STREAM_REMOVE_SCHED_STATS_EN
  logic [31:0] pkts_r;
  logic [31:0] bytes_r;

  // Popped packet and byte counters; clear wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkts_r  <= 32'd0;
      bytes_r <= 32'd0;
    end else if (stat_clr) begin
      pkts_r  <= 32'd0;
      bytes_r <= 32'd0;
    end else if (pop_s) begin
      pkts_r  <= pkts_r + 32'd1;
      bytes_r <= bytes_r + 32'(head_r.cnt);
    end else begin
      pkts_r  <= pkts_r;
      bytes_r <= bytes_r;
    end
  end

  assign stat_pkts  = pkts_r;
  assign stat_bytes = bytes_r;
`endif

  assign req_ready       = grant_s;
  assign valid_remove    = head_vld_r;
  assign byte_remove_cnt = head_r.cnt;
  assign cur_src         = head_r.src;
  assign pkt_done        = done_r;
  assign cmd_level       = level_r;

endmodule

// File: tb/tb_stream_remove_sched.sv
// Self-checking bench for stream_remove_sched: directed steps followed by a
// randomized phase, every cycle compared against a queue-based reference model.
// Statistics checks are included when STREAM_REMOVE_SCHED_STATS_EN is defined.
module tb_stream_remove_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sched_en;
  logic [3:0] req_valid;
  logic [7:0] req_cnt;
  logic [3:0] req_ready;
  logic       valid_remove;
  logic [1:0] byte_remove_cnt;
  logic       ready_remove;
  logic [1:0] cur_src;
  logic [3:0] pkt_done;
  logic [2:0] cmd_level;
`ifdef STREAM_REMOVE_SCHED_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_pkts;
  logic [31:0] stat_bytes;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  typedef struct { int src; int cnt; } cmd_t;
  cmd_t       q[$];
  int         rr;
  logic [3:0] m_done;
  int         m_pkts;
  int         m_bytes;

  always #5 clk = ~clk;

  stream_remove_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sched_en        (sched_en),
    .req_valid       (req_valid),
    .req_cnt         (req_cnt),
    .req_ready       (req_ready),
    .valid_remove    (valid_remove),
    .byte_remove_cnt (byte_remove_cnt),
    .ready_remove    (ready_remove),
    .cur_src         (cur_src),
    .pkt_done        (pkt_done),
`ifdef STREAM_REMOVE_SCHED_STATS_EN
    .stat_clr        (stat_clr),
    .stat_pkts       (stat_pkts),
    .stat_bytes      (stat_bytes),
`endif
    .cmd_level       (cmd_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant the model expects from the arbitration rules.
  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    bit can;
    g   = 4'b0000;
    can = sched_en && ((q.size() < 4) || (q.size() > 0 && ready_remove));
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (rr + k) % 4;
        if (req_valid[idx] && g == 4'b0000) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic int cnt_of(input int i);
    logic [7:0] v;
    v = req_cnt;
    return int'(v[i*2 +: 2]);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic [3:0] g;
    bit         pop;
    int         s;
    cmd_t       c;
    #1;
    g = exp_grant();
    check("req_ready", 32'(req_ready), 32'(g));
    check("valid_remove", 32'(valid_remove), (q.size() > 0) ? 32'd1 : 32'd0);
    check("byte_remove_cnt", 32'(byte_remove_cnt), (q.size() > 0) ? 32'(q[0].cnt) : 32'd0);
    check("cur_src", 32'(cur_src), (q.size() > 0) ? 32'(q[0].src) : 32'd0);
    check("cmd_level", 32'(cmd_level), 32'(q.size()));
    check("pkt_done", 32'(pkt_done), 32'(m_done));
`ifdef STREAM_REMOVE_SCHED_STATS_EN
    check("stat_pkts", stat_pkts, 32'(m_pkts));
    check("stat_bytes", stat_bytes, 32'(m_bytes));
`endif
    pop = (q.size() > 0) && ready_remove;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rr = 0; m_done = 4'b0000; m_pkts = 0; m_bytes = 0;
    end else begin
      m_done = pop ? (4'b0001 << q[0].src) : 4'b0000;
`ifdef STREAM_REMOVE_SCHED_STATS_EN
      if (stat_clr) begin
        m_pkts = 0; m_bytes = 0;
      end else if (pop) begin
        m_pkts++; m_bytes += q[0].cnt;
      end
`endif
      if (pop) void'(q.pop_front());
      if (g != 4'b0000) begin
        s = 0;
        for (int i = 0; i < 4; i++) if (g[i]) s = i;
        c.src = s; c.cnt = cnt_of(s);
        q.push_back(c);
        rr = (s + 1) % 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    sched_en = 1'b1; req_valid = 4'b0000; req_cnt = 8'h00; ready_remove = 1'b0;
`ifdef STREAM_REMOVE_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  initial begin
    q.delete(); rr = 0; m_done = 4'b0000; m_pkts = 0; m_bytes = 0;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();
    // Reset values
    check("rst_valid_remove", 32'(valid_remove), 32'd0);
    check("rst_cmd_level", 32'(cmd_level), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);

    // 1. single request from requester 0, cnt 2
    req_valid = 4'b0001; req_cnt = 8'b0000_0010;
    #1 check("t1_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    #1 check("t1_valid", 32'(valid_remove), 32'd1);
    check("t1_cnt", 32'(byte_remove_cnt), 32'd2);
    check("t1_src", 32'(cur_src), 32'd0);
    step();
    do_reset();

    // 2. all requesting, constant ready_remove: grants 0,1,2,3,0
    req_valid = 4'b1111; req_cnt = 8'b11_10_01_00; ready_remove = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1 check("t2_grant_order", 32'(req_ready), 32'(4'b0001 << (n % 4)));
      step();
    end
    for (int n = 0; n < 3; n++) step();
    idle_inputs();
    do_reset();

    // 3. fill to full, then push and pop together
    req_valid = 4'b1111; req_cnt = 8'b01_10_11_01;
    for (int n = 0; n < 4; n++) step();
    #1 check("t3_level_full", 32'(cmd_level), 32'd4);
    check("t3_no_grant_full", 32'(req_ready), 32'd0);
    step();
    req_valid = 4'b0100; ready_remove = 1'b1;
    #1 check("t3_grant_on_pop", 32'(req_ready), 32'h4);
    step();
    #1 check("t3_level_stays", 32'(cmd_level), 32'd4);
    idle_inputs();
    do_reset();

    // 4. sched_en low drains the queue without new grants
    req_valid = 4'b1111; req_cnt = 8'b10_01_11_10;
    for (int n = 0; n < 3; n++) step();
    sched_en = 1'b0; ready_remove = 1'b1;
    for (int n = 0; n < 4; n++) step();
    #1 check("t4_drained_level", 32'(cmd_level), 32'd0);
    check("t4_drained_valid", 32'(valid_remove), 32'd0);
    check("t4_no_grant", 32'(req_ready), 32'd0);
    step();
    idle_inputs();

    // 5. reset with two queued commands
    req_valid = 4'b0011; req_cnt = 8'b00_00_11_01;
    for (int n = 0; n < 2; n++) step();
    req_valid = 4'b0000; ready_remove = 1'b1;
    do_reset();
    #1 check("t5_level", 32'(cmd_level), 32'd0);
    check("t5_valid", 32'(valid_remove), 32'd0);
    check("t5_no_done", 32'(pkt_done), 32'd0);
    step();
    idle_inputs();

`ifdef STREAM_REMOVE_SCHED_STATS_EN
    // 6. statistics: pops of 1,3,2 then clear together with a pop
    do_reset();
    req_valid = 4'b0001;
    req_cnt = 8'h01; step();
    req_cnt = 8'h03; step();
    req_cnt = 8'h02; step();
    req_valid = 4'b0000; ready_remove = 1'b1;
    for (int n = 0; n < 4; n++) step();
    #1 check("t6_pkts", stat_pkts, 32'd3);
    check("t6_bytes", stat_bytes, 32'd6);
    ready_remove = 1'b0; req_valid = 4'b0001; req_cnt = 8'h03; step();
    req_valid = 4'b0000; ready_remove = 1'b1; stat_clr = 1'b1; step();
    stat_clr = 1'b0;
    #1 check("t6_clr_pkts", stat_pkts, 32'd0);
    check("t6_clr_bytes", stat_bytes, 32'd0);
    step();
    idle_inputs();
`endif

    // Randomized phase against the model
    for (int n = 0; n < 600; n++) begin
      req_valid    = 4'($urandom);
      req_cnt      = 8'($urandom);
      ready_remove = ($urandom_range(0, 3) != 0);
      sched_en     = ($urandom_range(0, 7) != 0);
      rst_n        = ($urandom_range(0, 99) != 0);
`ifdef STREAM_REMOVE_SCHED_STATS_EN
      stat_clr     = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
